// File: rtl/draw_scheduler.sv
// Arbitrates the board redraw engine and the tetromino engine onto the single VGA plot port.
// Requests are queued as pending flags and served board-first, then clear-old / draw-new.
module draw_scheduler #(
   parameter int TIMEOUT = 2048,
   parameter int GAP     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_board,
   input  logic       req_move,
   input  logic [4:0] old_x,
   input  logic [5:0] old_y,
   input  logic [4:0] new_x,
   input  logic [5:0] new_y,
   input  logic [2:0] block,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       board_en,
   input  logic       board_finished,
   input  logic [7:0] board_x,
   input  logic [6:0] board_y,
   input  logic [5:0] board_colour,
   output logic       tet_en,
   output logic       tet_clear,
   output logic [4:0] tet_x,
   output logic [5:0] tet_y,
   output logic [2:0] tet_block,
   input  logic       tet_complete,
   input  logic [7:0] tet_vx,
   input  logic [6:0] tet_vy,
   input  logic [5:0] tet_colour,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [5:0] vga_colour,
   output logic       vga_plot
);

   typedef enum logic [2:0] {IDLE, BOARD, GAP1, TCLR, GAP2, TDRAW, FIN} state_t;

   localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
   localparam int CW   = $clog2(CMAX + 1);

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic          pend_board, pend_move;
   logic          serve_board, serve_move, abort;
   logic          first, timeout, gap_end;
   logic [4:0]    hold_old_x, hold_new_x, act_old_x, act_new_x;
   logic [5:0]    hold_old_y, hold_new_y, act_old_y, act_new_y;
   logic [2:0]    hold_block, act_block;

   assign first   = (cnt == '0);
   assign timeout = (cnt == CW'(TIMEOUT - 1));
   assign gap_end = (cnt == CW'(GAP - 1));
   assign busy    = (state != IDLE) | pend_board | pend_move;

   // One counter serves as both the gap timer and the per-pass watchdog; it restarts on every state change.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            cnt <= '0;
         else if (state inside {BOARD, GAP1, TCLR, GAP2, TDRAW})
            cnt <= cnt + 1'b1;
      end
   end

   // Pending requests, the move coordinates waiting for service, and the copy the running passes use.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_board <= 1'b0;
         pend_move  <= 1'b0;
         error      <= 1'b0;
         hold_old_x <= '0;
         hold_old_y <= '0;
         hold_new_x <= '0;
         hold_new_y <= '0;
         hold_block <= '0;
         act_old_x  <= '0;
         act_old_y  <= '0;
         act_new_x  <= '0;
         act_new_y  <= '0;
         act_block  <= '0;
      end else begin
         pend_board <= req_board | (pend_board & ~serve_board);
         pend_move  <= req_move | (pend_move & ~serve_move);
         if (abort)
            error <= 1'b1;
         if (req_move) begin
            hold_old_x <= old_x;
            hold_old_y <= old_y;
            hold_new_x <= new_x;
            hold_new_y <= new_y;
            hold_block <= block;
         end
         if (serve_move) begin
            act_old_x <= hold_old_x;
            act_old_y <= hold_old_y;
            act_new_x <= hold_new_x;
            act_new_y <= hold_new_y;
            act_block <= hold_block;
         end
      end
   end

   // The first cycle of every engine pass is its reset edge, so plotting starts on the second cycle.
   always_comb begin
      state_next  = state;
      serve_board = 1'b0;
      serve_move  = 1'b0;
      abort       = 1'b0;
      done        = 1'b0;
      board_en    = 1'b0;
      tet_en      = 1'b0;
      tet_clear   = 1'b0;
      tet_x       = '0;
      tet_y       = '0;
      tet_block   = '0;
      vga_x       = '0;
      vga_y       = '0;
      vga_colour  = '0;
      vga_plot    = 1'b0;
      case (state)
         IDLE, FIN: begin
            done = (state == FIN);
            if (pend_board) begin
               state_next  = BOARD;
               serve_board = 1'b1;
            end else if (pend_move) begin
               state_next = TCLR;
               serve_move = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         BOARD: begin
            board_en   = 1'b1;
            vga_x      = board_x;
            vga_y      = board_y;
            vga_colour = board_colour;
            vga_plot   = !first && !board_finished;
            if (!first && board_finished)
               state_next = pend_move ? GAP1 : FIN;
            else if (timeout) begin
               state_next = FIN;
               abort      = 1'b1;
            end
         end
         GAP1: begin
            if (gap_end) begin
               state_next = TCLR;
               serve_move = 1'b1;
            end
         end
         GAP2: begin
            if (gap_end)
               state_next = TDRAW;
         end
         TCLR, TDRAW: begin
            tet_en     = 1'b1;
            tet_clear  = (state == TCLR);
            tet_x      = (state == TCLR) ? act_old_x : act_new_x;
            tet_y      = (state == TCLR) ? act_old_y : act_new_y;
            tet_block  = act_block;
            vga_x      = tet_vx;
            vga_y      = tet_vy;
            vga_colour = tet_colour;
            vga_plot   = !first && !tet_complete;
            if (tet_complete)
               state_next = (state == TCLR) ? GAP2 : FIN;
            else if (timeout) begin
               state_next = FIN;
               abort      = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: small engine models drive the inputs, and an expected per-cycle
// output trace is built from whole passes (request, pass, gap, pass, done) and compared every cycle.
module tb_draw_scheduler;

   localparam int TIMEOUT = 2048;
   localparam int GAP     = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_board, req_move;
   logic [4:0] old_x, new_x;
   logic [5:0] old_y, new_y;
   logic [2:0] block;
   logic       busy, done, error;
   logic       board_en, board_finished;
   logic [7:0] board_x;
   logic [6:0] board_y;
   logic [5:0] board_colour;
   logic       tet_en, tet_clear, tet_complete;
   logic [4:0] tet_x;
   logic [5:0] tet_y;
   logic [2:0] tet_block;
   logic [7:0] tet_vx;
   logic [6:0] tet_vy;
   logic [5:0] tet_colour;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [5:0] vga_colour;
   logic       vga_plot;

   draw_scheduler #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
      .clk(clk), .reset(reset), .req_board(req_board), .req_move(req_move),
      .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y), .block(block),
      .busy(busy), .done(done), .error(error),
      .board_en(board_en), .board_finished(board_finished),
      .board_x(board_x), .board_y(board_y), .board_colour(board_colour),
      .tet_en(tet_en), .tet_clear(tet_clear), .tet_x(tet_x), .tet_y(tet_y),
      .tet_block(tet_block), .tet_complete(tet_complete),
      .tet_vx(tet_vx), .tet_vy(tet_vy), .tet_colour(tet_colour),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   always #5 clk = ~clk;

   // Engine models: each finishes once it has been enabled for *_len earlier cycles.
   int bcnt = 0, tcnt = 0;
   int board_len = 800, tet_len = 64;
   always @(posedge clk) begin
      bcnt <= board_en ? bcnt + 1 : 0;
      tcnt <= tet_en ? tcnt + 1 : 0;
   end
   assign board_finished = board_en && (bcnt == board_len);
   assign board_x        = 8'(bcnt * 3 + 1);
   assign board_y        = 7'(bcnt * 5 + 2);
   assign board_colour   = 6'(bcnt + 7);
   assign tet_complete   = tet_en && (tcnt == tet_len);
   assign tet_vx         = 8'(tcnt * 7 + 3);
   assign tet_vy         = 7'(tcnt * 11 + 4);
   assign tet_colour     = 6'(tcnt * 2 + 9);

   typedef struct {
      logic       busy, done, error, board_en, tet_en, tet_clear, vga_plot;
      logic [4:0] tx;
      logic [5:0] ty;
      logic [2:0] tb;
      logic [7:0] vx;
      logic [6:0] vy;
      logic [5:0] vc;
   } exp_t;

   exp_t expq[$];
   bit   model_err = 1'b0;
   bit   checking  = 1'b0;
   int   checks = 0, errors = 0;
   int   plot_cnt = 0, ben_cnt = 0, ten_cnt = 0, done_cnt = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic exp_t idle_rec(input bit b);
      exp_t r;
      r = '{default: 0};
      r.busy  = b;
      r.error = model_err;
      return r;
   endfunction

   task automatic push_idle(input bit b);
      expq.push_back(idle_rec(b));
   endtask

   task automatic push_gap();
      repeat (GAP) expq.push_back(idle_rec(1'b1));
   endtask

   task automatic push_fin();
      exp_t r;
      r = idle_rec(1'b1);
      r.done = 1'b1;
      expq.push_back(r);
   endtask

   // A pass finishing at engine count n lasts n+1 cycles unless the watchdog cuts it at TIMEOUT cycles.
   task automatic push_board(input int n);
      exp_t r;
      int last;
      last = (n <= TIMEOUT - 1) ? n : TIMEOUT - 1;
      for (int k = 0; k <= last; k++) begin
         r = idle_rec(1'b1);
         r.board_en = 1'b1;
         r.vx = 8'(k * 3 + 1);
         r.vy = 7'(k * 5 + 2);
         r.vc = 6'(k + 7);
         r.vga_plot = (k >= 1) && (k != n);
         expq.push_back(r);
      end
      if (n > TIMEOUT - 1) model_err = 1'b1;
   endtask

   task automatic push_tet(input bit clr, input logic [4:0] x, input logic [5:0] y,
                           input logic [2:0] blk, input int n, input int keep);
      exp_t r;
      int last;
      last = (n <= TIMEOUT - 1) ? n : TIMEOUT - 1;
      for (int k = 0; k <= last && k < keep; k++) begin
         r = idle_rec(1'b1);
         r.tet_en = 1'b1;
         r.tet_clear = clr;
         r.tx = x;
         r.ty = y;
         r.tb = blk;
         r.vx = 8'(k * 7 + 3);
         r.vy = 7'(k * 11 + 4);
         r.vc = 6'(k * 2 + 9);
         r.vga_plot = (k >= 1) && (k != n);
         expq.push_back(r);
      end
      if (n > TIMEOUT - 1 && keep > last) model_err = 1'b1;
   endtask

   always @(negedge clk) begin
      if (checking) begin
         exp_t e;
         if (expq.size() > 0) e = expq.pop_front();
         else e = idle_rec(1'b0);
         checkOutput("busy", busy, e.busy);
         checkOutput("done", done, e.done);
         checkOutput("error", error, e.error);
         checkOutput("board_en", board_en, e.board_en);
         checkOutput("tet_en", tet_en, e.tet_en);
         checkOutput("tet_clear", tet_clear, e.tet_clear);
         checkOutput("tet_x", tet_x, e.tx);
         checkOutput("tet_y", tet_y, e.ty);
         checkOutput("tet_block", tet_block, e.tb);
         checkOutput("vga_x", vga_x, e.vx);
         checkOutput("vga_y", vga_y, e.vy);
         checkOutput("vga_colour", vga_colour, e.vc);
         checkOutput("vga_plot", vga_plot, e.vga_plot);
         if (vga_plot) plot_cnt++;
         if (board_en) ben_cnt++;
         if (tet_en) ten_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic clear_counts();
      plot_cnt = 0;
      ben_cnt  = 0;
      ten_cnt  = 0;
      done_cnt = 0;
   endtask

   task automatic applyStimulus(input bit rb, input bit rm, input logic [4:0] ox, input logic [5:0] oy,
                                input logic [4:0] nx, input logic [5:0] ny, input logic [2:0] blk);
      req_board = rb;
      req_move  = rm;
      old_x = ox;
      old_y = oy;
      new_x = nx;
      new_y = ny;
      block = blk;
      @(posedge clk);
      #1;
      req_board = 1'b0;
      req_move  = 1'b0;
   endtask

   task automatic wait_drain();
      int budget;
      budget = 5000;
      while (expq.size() != 0 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      checkOutput("drain", expq.size(), 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1;
      req_board = 1'b0;
      req_move = 1'b0;
      old_x = '0;
      old_y = '0;
      new_x = '0;
      new_y = '0;
      block = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checking = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end

      $display("[TB] move old=(3,4) new=(3,5)");
      tet_len = 64;
      clear_counts();
      push_idle(1'b0);
      push_idle(1'b1);
      push_tet(1'b1, 5'd3, 6'd4, 3'd2, 64, 1 << 30);
      push_gap();
      push_tet(1'b0, 5'd3, 6'd5, 3'd2, 64, 1 << 30);
      push_fin();
      applyStimulus(1'b0, 1'b1, 5'd3, 6'd4, 5'd3, 6'd5, 3'd2);
      wait_drain();
      checkOutput("move_plot_count", plot_cnt, 126);
      checkOutput("move_tet_en_count", ten_cnt, 130);
      checkOutput("move_done_count", done_cnt, 1);

      $display("[TB] board redraw alone");
      board_len = 800;
      clear_counts();
      push_idle(1'b0);
      push_idle(1'b1);
      push_board(800);
      push_fin();
      applyStimulus(1'b1, 1'b0, 5'd0, 6'd0, 5'd0, 6'd0, 3'd0);
      wait_drain();
      checkOutput("board_en_count", ben_cnt, 801);
      checkOutput("board_plot_count", plot_cnt, 799);
      checkOutput("board_done_count", done_cnt, 1);
      checkOutput("board_tet_en_count", ten_cnt, 0);

      $display("[TB] simultaneous board and move");
      board_len = 20;
      tet_len = 10;
      clear_counts();
      push_idle(1'b0);
      push_idle(1'b1);
      push_board(20);
      push_gap();
      push_tet(1'b1, 5'd1, 6'd2, 3'd5, 10, 1 << 30);
      push_gap();
      push_tet(1'b0, 5'd9, 6'd33, 3'd5, 10, 1 << 30);
      push_fin();
      applyStimulus(1'b1, 1'b1, 5'd1, 6'd2, 5'd9, 6'd33, 3'd5);
      wait_drain();
      checkOutput("simul_done_count", done_cnt, 1);

      $display("[TB] move arriving mid-board");
      board_len = 50;
      tet_len = 12;
      clear_counts();
      push_idle(1'b0);
      push_idle(1'b1);
      push_board(50);
      push_gap();
      push_tet(1'b1, 5'd6, 6'd9, 3'd3, 12, 1 << 30);
      push_gap();
      push_tet(1'b0, 5'd7, 6'd10, 3'd3, 12, 1 << 30);
      push_fin();
      applyStimulus(1'b1, 1'b0, 5'd0, 6'd0, 5'd0, 6'd0, 3'd0);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      applyStimulus(1'b0, 1'b1, 5'd6, 6'd9, 5'd7, 6'd10, 3'd3);
      wait_drain();
      checkOutput("midboard_done_count", done_cnt, 1);
      checkOutput("midboard_board_en_count", ben_cnt, 51);

      $display("[TB] tetromino engine never completes");
      tet_len = 100000;
      clear_counts();
      push_idle(1'b0);
      push_idle(1'b1);
      push_tet(1'b1, 5'd2, 6'd8, 3'd1, 100000, 1 << 30);
      push_fin();
      applyStimulus(1'b0, 1'b1, 5'd2, 6'd8, 5'd2, 6'd9, 3'd1);
      wait_drain();
      checkOutput("timeout_tet_en_count", ten_cnt, 2048);
      checkOutput("timeout_done_count", done_cnt, 1);
      checkOutput("error_sticky", error, 1);

      $display("[TB] reset during draw pass");
      tet_len = 30;
      clear_counts();
      push_idle(1'b0);
      push_idle(1'b1);
      push_tet(1'b1, 5'd4, 6'd20, 3'd6, 30, 1 << 30);
      push_gap();
      push_tet(1'b0, 5'd5, 6'd21, 3'd6, 30, 5);
      model_err = 1'b0;
      applyStimulus(1'b0, 1'b1, 5'd4, 6'd20, 5'd5, 6'd21, 3'd6);
      repeat (37) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_drain();
      checkOutput("reset_done_count", done_cnt, 0);
      checkOutput("reset_error_cleared", error, 0);

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
